// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between NUM_REQ byte producers
// Optional feature macro: UART_ARB_LOCK_EN (message lock driven by req_last)

module uart_tx_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_start,
    output logic [7:0]           uart_data,
    input  logic                 uart_done,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [IDW:0]   NREQ     = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic            done_q;
    logic            lock;
    logic            found;
    logic [IDW-1:0]  winner;
    logic [IDW:0]    idx;
    logic [IDW-1:0]  ptr_next;
    logic            completion;

    // tx_done may be held high across bytes, so only its rising edge counts
    assign completion = uart_done & ~done_q;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        if (i == LAST_IDX) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Pick the first valid requester starting at rr_ptr; a held lock restricts the choice to the owner
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
        if (lock) begin
            found  = req_valid[grant_id];
            winner = grant_id;
        end
    end

    // One-hot accept, only while idle so a byte is never taken with another in flight
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

`ifdef UART_ARB_LOCK_EN
    // Pointer stays put mid-message and moves past the owner once its last byte is taken
    always_comb begin
        ptr_next = rr_ptr;
        if (req_last[winner]) begin
            ptr_next = next_idx(winner);
        end
    end

    // Lock is held from a non-last byte until the owner's last byte is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock <= 1'b0;
        end else if (state == IDLE && found) begin
            lock <= ~req_last[winner];
        end
    end
`else
    logic unused_last;

    assign lock        = 1'b0;
    assign unused_last = ^req_last;

    // Plain per-byte round robin: next search starts just after the winner
    always_comb begin
        ptr_next = next_idx(winner);
    end
`endif

    // Control FSM: grant in IDLE, pulse start, then wait for the serializer's completion edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            uart_start <= 1'b0;
            uart_data  <= 8'h00;
            busy       <= 1'b0;
            grant_id   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= uart_done;
            uart_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        uart_data  <= req_data[{winner, 3'b000} +: 8];
                        grant_id   <= winner;
                        rr_ptr     <= ptr_next;
                        uart_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (completion) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           uart_start;
    logic [7:0]     uart_data;
    logic           uart_done;
    logic           busy;
    logic [1:0]     grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_start (uart_start),
        .uart_data  (uart_data),
        .uart_done  (uart_done),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // producer queues: {last, data}
    logic [8:0] qbuf [N][64];
    int         qh [N];
    int         qt [N];
    logic [N-1:0] acc = '0;
    logic       st_s = 1'b0;
    bit         stall_en = 1'b0;
    bit         done_level = 1'b0;
    bit         do_rst = 1'b0;
    int         cnt = 0;
    int         hold = 0;
    int         glog_id [$];
    int         glog_data [$];

    task automatic push(input int i, input logic [8:0] v);
        qbuf[i][qt[i] % 64] = v;
        qt[i]++;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (qt[i] != qh[i]) return 1'b0;
        return 1'b1;
    endfunction

    // drive producers and the uart_tx stand-in for the next cycle
    task automatic apply();
        rst    = do_rst;
        do_rst = 1'b0;
        for (int i = 0; i < N; i++) if (acc[i]) qh[i]++;
        for (int i = 0; i < N; i++) begin
            if (qt[i] != qh[i] && !(stall_en && $urandom_range(0, 3) == 0)) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = qbuf[i][qh[i] % 64][7:0];
                req_last[i]         = qbuf[i][qh[i] % 64][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
        if (rst) begin
            cnt = 0; hold = 0; uart_done = 1'b0;
        end else if (st_s) begin
            uart_done = 1'b0;
            cnt = $urandom_range(2, 6);
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                uart_done = 1'b1;
                hold = done_level ? 0 : $urandom_range(1, 3);
            end
        end else if (uart_done && hold > 0) begin
            hold--;
            if (hold == 0) uart_done = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply();
        @(negedge clk);
        acc  = rst ? '0 : req_ready;
        st_s = uart_start;
        if (uart_start && !rst) begin
            glog_id.push_back(int'(grant_id));
            glog_data.push_back(int'(uart_data));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (n < 2000 && (!queues_empty() || busy || uart_start)) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got busy=%0b expected idle within 2000 cycles", busy);
        end
    endtask

    task automatic wait_grants(input int num);
        int n = 0;
        while (n < 500 && glog_id.size() < num) begin
            step();
            n++;
        end
        chk("grant_count", glog_id.size() >= num, 1);
    endtask

    // ---------------- reference model ----------------
    bit m_avail = 1'b1;
    bit m_start = 1'b0;
    int m_id    = 0;
    int m_data  = 0;
    int m_ptr   = 0;
    bit m_prev  = 1'b0;
    bit m_lock  = 1'b0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // compare DUT with the model every cycle, then advance the model across the coming edge
    always @(negedge clk) begin : cmp
        int w;
        logic [N-1:0] er;
        if (rst) begin
            m_avail = 1'b1; m_start = 1'b0; m_id = 0; m_data = 0;
            m_ptr = 0; m_prev = 1'b0; m_lock = 1'b0;
        end else begin
            w = -1;
            if (m_avail) begin
                if (m_lock) w = req_valid[m_id] ? m_id : -1;
                else        w = pick(req_valid, m_ptr);
            end
            er = (w >= 0) ? N'(1 << w) : '0;
            chk("req_ready", req_ready, er);
            chk("uart_start", uart_start, m_start);
            chk("busy", busy, !m_avail);
            chk("grant_id", grant_id, m_id);
            chk("uart_data", uart_data, m_data);
            if (w >= 0) begin
                m_id    = w;
                m_data  = int'(req_data[w*8 +: 8]);
                m_avail = 1'b0;
                m_start = 1'b1;
`ifdef UART_ARB_LOCK_EN
                m_lock = !req_last[w];
                if (req_last[w]) m_ptr = (w + 1) % N;
`else
                m_ptr = (w + 1) % N;
`endif
            end else if (m_start) begin
                m_start = 1'b0;
            end else if (!m_avail && uart_done && !m_prev) begin
                m_avail = 1'b1;
            end
            m_prev = uart_done;
        end
    end

    initial begin
        int lk_exp [4];
        req_valid = '0; req_data = '0; req_last = '0; uart_done = 1'b0;
        for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end

        // reset values
        do_rst = 1'b1; step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_start", uart_start, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", uart_data, 8'h00);

        // single requester 2
        push(2, {1'b1, 8'hA5});
        step();
        chk("single_ready", req_ready, 4'b0100);
        step();
        chk("single_start", uart_start, 1);
        chk("single_data", uart_data, 8'hA5);
        chk("single_grant", grant_id, 2);
        drain();

        // wrap: pointer now 3
        glog_id.delete(); glog_data.delete();
        push(0, {1'b1, 8'h30});
        push(3, {1'b1, 8'h33});
        drain();
        chk("wrap_n", glog_id.size(), 2);
        if (glog_id.size() >= 2) begin
            chk("wrap_g0", glog_id[0], 3);
            chk("wrap_g1", glog_id[1], 0);
            chk("wrap_d0", glog_data[0], 8'h33);
        end

        // reset in the middle of a WAIT
        push(1, {1'b1, 8'h55});
        for (int n = 0; n < 20 && !(busy && !uart_start); n++) step();
        chk("reached_wait", busy && !uart_start, 1);
        glog_id.delete(); glog_data.delete();
        do_rst = 1'b1; step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", uart_start, 0);
        chk("mid_rst_grant", grant_id, 0);
        chk("mid_rst_ready", req_ready, 0);
        step();
        uart_done = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("spurious_busy", busy, 0);
        end
        uart_done = 1'b0;
        step();
        chk("spurious_nogrant", glog_id.size(), 0);

        // fairness with done held high between bytes
        do_rst = 1'b1; step();
        done_level = 1'b1;
        glog_id.delete(); glog_data.delete();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 5; j++) push(i, {1'b1, 8'(8'h10 + i)});
        wait_grants(5);
        if (glog_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("fair_grant", glog_id[k], k % 4);
                chk("fair_data", glog_data[k], 8'h10 + (k % 4));
            end
        end
        drain();

        // message lock
        do_rst = 1'b1; step();
        done_level = 1'b0;
        glog_id.delete(); glog_data.delete();
        push(0, {1'b0, 8'h40}); push(0, {1'b0, 8'h41}); push(0, {1'b1, 8'h42});
        for (int j = 0; j < 4; j++) push(1, {1'b1, 8'(8'h50 + j)});
`ifdef UART_ARB_LOCK_EN
        lk_exp = '{0, 0, 0, 1};
`else
        lk_exp = '{0, 1, 0, 1};
`endif
        wait_grants(4);
        if (glog_id.size() >= 4)
            for (int k = 0; k < 4; k++) chk("lock_grant", glog_id[k], lk_exp[k]);
        drain();

        // randomized traffic
        do_rst = 1'b1; step();
        stall_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (c % 500 == 0) done_level = 1'($urandom);
            r = $urandom_range(0, N - 1);
            if ($urandom_range(0, 2) == 0 && (qt[r] - qh[r]) < 8)
                push(r, 9'($urandom));
            if ($urandom_range(0, 999) == 0) do_rst = 1'b1;
            step();
        end
        for (int i = 0; i < N; i++) push(i, {1'b1, 8'($urandom)});
        stall_en = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
